// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester mem16kb arbiter.
package mem_arb_pkg;

    localparam int DEF_AWIDTH    = 12;
    localparam int DEF_DWIDTH    = 16;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    typedef enum logic {
        RQ0 = 1'b0,
        RQ1 = 1'b1
    } rq_id_e;

    // One slot of the read-return pipeline.
    typedef struct packed {
        logic   valid;
        logic   rd;
        rq_id_e id;
    } pipe_stage_t;

endpackage

// File: rtl/mem16kb_arbiter_if.sv
// Requester and memory-side signal bundle; slave is the arbiter's view, master the environment's.
interface mem16kb_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH
);
    logic              rq0_req;
    logic              rq0_wr;
    logic [AWIDTH-1:0] rq0_addr;
    logic [DWIDTH-1:0] rq0_wdata;
    logic              rq0_gnt;
    logic              rq0_rvalid;
    logic [DWIDTH-1:0] rq0_rdata;

    logic              rq1_req;
    logic              rq1_wr;
    logic [AWIDTH-1:0] rq1_addr;
    logic [DWIDTH-1:0] rq1_wdata;
    logic              rq1_gnt;
    logic              rq1_rvalid;
    logic [DWIDTH-1:0] rq1_rdata;

    logic [AWIDTH-1:0] mem_address;
    logic [DWIDTH-1:0] mem_data_in;
    logic              mem_write_enable_n;
    logic [DWIDTH-1:0] mem_data_out;

    modport slave (
        input  rq0_req, rq0_wr, rq0_addr, rq0_wdata,
        input  rq1_req, rq1_wr, rq1_addr, rq1_wdata,
        input  mem_data_out,
        output rq0_gnt, rq0_rvalid, rq0_rdata,
        output rq1_gnt, rq1_rvalid, rq1_rdata,
        output mem_address, mem_data_in, mem_write_enable_n
    );

    modport master (
        output rq0_req, rq0_wr, rq0_addr, rq0_wdata,
        output rq1_req, rq1_wr, rq1_addr, rq1_wdata,
        output mem_data_out,
        input  rq0_gnt, rq0_rvalid, rq0_rdata,
        input  rq1_gnt, rq1_rvalid, rq1_rdata,
        input  mem_address, mem_data_in, mem_write_enable_n
    );

endinterface

// File: rtl/rr2_grant.sv
// Two-way round-robin grant FSM with a burst limit that only bites while the other side is waiting.
module rr2_grant
    import mem_arb_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic clk,
    input  logic areset_n,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);
    localparam int            CW      = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    arb_state_e    state_q, state_d;
    rq_id_e        last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt0, gnt1;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= IDLE;
            last_q  <= RQ1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (req0_i && req1_i) begin
                    gnt0 = (last_q == RQ1);
                    gnt1 = (last_q == RQ0);
                end else begin
                    gnt0 = req0_i;
                    gnt1 = req1_i;
                end
            end
            OWN0: begin
                gnt0 = req0_i && (!req1_i || (cnt_q < MAX_CNT));
                gnt1 = req1_i && !gnt0;
            end
            OWN1: begin
                gnt1 = req1_i && (!req0_i || (cnt_q < MAX_CNT));
                gnt0 = req0_i && !gnt1;
            end
            default: ;
        endcase

        // Counter saturates so a lone owner can stream forever yet yields at once when challenged.
        if (gnt0) begin
            state_d = OWN0;
            last_d  = RQ0;
            cnt_d   = (state_q != OWN0) ? ONE_CNT :
                      (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;
        end else if (gnt1) begin
            state_d = OWN1;
            last_d  = RQ1;
            cnt_d   = (state_q != OWN1) ? ONE_CNT :
                      (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    assign gnt0_o = gnt0 && areset_n;
    assign gnt1_o = gnt1 && areset_n;

endmodule

// File: rtl/mem16kb_arbiter.sv
// Arbitrates two requesters onto one mem16kb port; registers the memory command and routes read data back.
module mem16kb_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH    = DEF_AWIDTH,
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input logic              clk,
    input logic              areset_n,
    mem16kb_arbiter_if.slave bus
);
    logic              gnt0, gnt1, accept, acc_wr;
    rq_id_e            acc_id;
    logic [AWIDTH-1:0] acc_addr;
    logic [DWIDTH-1:0] acc_wdata;
    logic              ret0, ret1;

    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0] mem_din_q, mem_din_d;
    logic              mem_wen_n_q, mem_wen_n_d;
    pipe_stage_t       s1_q, s1_d, s2_q;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DWIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    rr2_grant #(
        .MAX_BURST(MAX_BURST)
    ) u_grant (
        .clk     (clk),
        .areset_n(areset_n),
        .req0_i  (bus.rq0_req),
        .req1_i  (bus.rq1_req),
        .gnt0_o  (gnt0),
        .gnt1_o  (gnt1)
    );

    always_comb begin
        accept    = gnt0 | gnt1;
        acc_id    = gnt1 ? RQ1 : RQ0;
        acc_wr    = gnt1 ? bus.rq1_wr    : bus.rq0_wr;
        acc_addr  = gnt1 ? bus.rq1_addr  : bus.rq0_addr;
        acc_wdata = gnt1 ? bus.rq1_wdata : bus.rq0_wdata;

        mem_addr_d  = accept ? acc_addr  : mem_addr_q;
        mem_din_d   = accept ? acc_wdata : mem_din_q;
        mem_wen_n_d = !(accept && acc_wr);

        s1_d = '{valid: accept, rd: !acc_wr, id: acc_id};

        // Stage 2 lines up with the cycle in which mem16kb presents the data for that read.
        ret0      = s2_q.valid && s2_q.rd && (s2_q.id == RQ0);
        ret1      = s2_q.valid && s2_q.rd && (s2_q.id == RQ1);
        rvalid0_d = ret0;
        rvalid1_d = ret1;
        rdata0_d  = ret0 ? bus.mem_data_out : rdata0_q;
        rdata1_d  = ret1 ? bus.mem_data_out : rdata1_q;
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_wen_n_q <= 1'b1;
            s1_q        <= '0;
            s2_q        <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_wen_n_q <= mem_wen_n_d;
            s1_q        <= s1_d;
            s2_q        <= s1_q;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign bus.rq0_gnt            = gnt0;
    assign bus.rq1_gnt            = gnt1;
    assign bus.rq0_rvalid         = rvalid0_q;
    assign bus.rq1_rvalid         = rvalid1_q;
    assign bus.rq0_rdata          = rdata0_q;
    assign bus.rq1_rdata          = rdata1_q;
    assign bus.mem_address        = mem_addr_q;
    assign bus.mem_data_in        = mem_din_q;
    assign bus.mem_write_enable_n = mem_wen_n_q;

endmodule

// File: tb/tb_mem16kb_arbiter.sv
// Self-checking bench: a mem16kb behavioural memory plus a run-length arbitration model and read scoreboard.
module tb_mem16kb_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 12;
    localparam int DW   = 16;
    localparam int MAXB = 4;

    typedef struct {
        int          id;
        logic [15:0] data;
        int          due;
    } rd_exp_t;

    logic clk = 1'b0;
    logic areset_n;
    logic memLoad;

    mem16kb_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    mem16kb_arbiter #(
        .AWIDTH   (AW),
        .DWIDTH   (DW),
        .MAX_BURST(MAXB)
    ) dut (
        .clk     (clk),
        .areset_n(areset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pattern(int i);
        return 16'(i * 40503 + 12345);
    endfunction

    logic [15:0] physMem [0:4095];

    // Synchronous single-port memory: address sampled on the edge, data_out valid the following cycle.
    always @(posedge clk) begin
        if (memLoad) begin
            for (int i = 0; i < 4096; i++) physMem[i] <= pattern(i);
        end else begin
            if (!bus.mem_write_enable_n) physMem[bus.mem_address] <= bus.mem_data_in;
            bus.mem_data_out <= physMem[bus.mem_address];
        end
    end

    int checks = 0;
    int failures = 0;
    int edgeCnt = 0;

    int          lastId, runLen, expGnt;
    bit          mIdle;
    logic [15:0] refMem [0:4095];
    rd_exp_t     rdQ[$];

    logic          obsGnt0, obsGnt1, expG0, expG1;
    logic          obsRv0, obsRv1, expRv0, expRv1;
    logic [15:0]   obsRd0, obsRd1, expData;
    logic          obsWeN, expWeN;
    logic [AW-1:0] obsAddr, expAddr;
    logic [DW-1:0] obsDin, expDin;

    task modelReset();
        lastId  = 1;
        mIdle   = 1'b1;
        runLen  = 0;
        rdQ.delete();
        expAddr = '0;
        expDin  = '0;
        expWeN  = 1'b1;
    endtask

    function automatic int modelGrant(logic r0, logic r1);
        if (r0 && r1) begin
            if (mIdle || runLen >= MAXB) return 1 - lastId;
            return lastId;
        end
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task modelUpdate(input int g);
        if (g < 0) begin
            mIdle  = 1'b1;
            runLen = 0;
        end else begin
            if (!mIdle && g == lastId) runLen = (runLen < MAXB) ? runLen + 1 : MAXB;
            else runLen = 1;
            lastId = g;
            mIdle  = 1'b0;
        end
    endtask

    task setReq(input int id, input logic req, input logic wr, input int addr, input logic [15:0] data);
        if (id == 0) begin
            bus.rq0_req = req; bus.rq0_wr = wr; bus.rq0_addr = AW'(addr); bus.rq0_wdata = data;
        end else begin
            bus.rq1_req = req; bus.rq1_wr = wr; bus.rq1_addr = AW'(addr); bus.rq1_wdata = data;
        end
    endtask

    task newTxn(input int id);
        setReq(id, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 16'($urandom));
    endtask

    // Advances one clock: samples grants mid-cycle, predicts the accept, then samples registered outputs.
    task clockStep();
        rd_exp_t     e;
        logic        wr;
        logic [11:0] addr;
        logic [15:0] data;
        @(negedge clk);
        obsGnt0 = bus.rq0_gnt;
        obsGnt1 = bus.rq1_gnt;
        expGnt  = modelGrant(bus.rq0_req, bus.rq1_req);
        expG0   = (expGnt == 0);
        expG1   = (expGnt == 1);
        @(posedge clk);
        #1;
        edgeCnt++;
        expWeN = 1'b1;
        if (expGnt >= 0) begin
            wr   = (expGnt == 0) ? bus.rq0_wr    : bus.rq1_wr;
            addr = (expGnt == 0) ? bus.rq0_addr  : bus.rq1_addr;
            data = (expGnt == 0) ? bus.rq0_wdata : bus.rq1_wdata;
            expAddr = addr;
            expDin  = data;
            expWeN  = !wr;
            if (wr) refMem[addr] = data;
            else begin
                e.id = expGnt; e.data = refMem[addr]; e.due = edgeCnt + 2;
                rdQ.push_back(e);
            end
        end
        modelUpdate(expGnt);
        expRv0 = 1'b0;
        expRv1 = 1'b0;
        if (rdQ.size() > 0 && rdQ[0].due == edgeCnt) begin
            e = rdQ.pop_front();
            if (e.id == 0) expRv0 = 1'b1; else expRv1 = 1'b1;
            expData = e.data;
        end
        obsRv0  = bus.rq0_rvalid;
        obsRv1  = bus.rq1_rvalid;
        obsRd0  = bus.rq0_rdata;
        obsRd1  = bus.rq1_rdata;
        obsWeN  = bus.mem_write_enable_n;
        obsAddr = bus.mem_address;
        obsDin  = bus.mem_data_in;
    endtask

    task doReset();
        @(posedge clk);
        #1;
        areset_n = 1'b0;
        setReq(0, 1'b0, 1'b0, 0, 16'h0);
        setReq(1, 1'b0, 1'b0, 0, 16'h0);
        @(posedge clk);
        #1;
        areset_n = 1'b1;
        modelReset();
    endtask

    task test_reset();
        areset_n = 1'b0;
        memLoad  = 1'b1;
        setReq(0, 1'b1, 1'b0, 5, 16'h0);
        setReq(1, 1'b1, 1'b0, 6, 16'h0);
        for (int i = 0; i < 4096; i++) refMem[i] = pattern(i);
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.rq0_gnt, bus.rq1_gnt} !== 2'b00) begin
            failures++; $display("[TB] FAIL reset_gnt actual=%b%b expected=00", bus.rq0_gnt, bus.rq1_gnt);
        end
        checks++;
        if (bus.mem_write_enable_n !== 1'b1 || bus.mem_address !== '0 || bus.mem_data_in !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mem actual we_n=%b addr=%0d din=%0d expected we_n=1 addr=0 din=0",
                     bus.mem_write_enable_n, bus.mem_address, bus.mem_data_in);
        end
        checks++;
        if ({bus.rq0_rvalid, bus.rq1_rvalid} !== 2'b00 || bus.rq0_rdata !== '0 || bus.rq1_rdata !== '0) begin
            failures++;
            $display("[TB] FAIL reset_read actual rv=%b%b rd0=%0d rd1=%0d expected rv=00 rd0=0 rd1=0",
                     bus.rq0_rvalid, bus.rq1_rvalid, bus.rq0_rdata, bus.rq1_rdata);
        end
        @(posedge clk);
        #1;
        memLoad  = 1'b0;
        setReq(0, 1'b0, 1'b0, 0, 16'h0);
        setReq(1, 1'b0, 1'b0, 0, 16'h0);
        areset_n = 1'b1;
    endtask

    task test_write_read();
        setReq(0, 1'b1, 1'b1, 1, 16'd14514);
        clockStep();
        checks++;
        if ({obsGnt0, obsGnt1} !== {expG0, expG1}) begin
            failures++; $display("[TB] FAIL wr_gnt actual=%b%b expected=%b%b", obsGnt0, obsGnt1, expG0, expG1);
        end
        checks++;
        if (obsWeN !== expWeN || obsAddr !== expAddr || obsDin !== expDin) begin
            failures++;
            $display("[TB] FAIL wr_membus actual we_n=%b addr=%0d din=%0d expected we_n=%b addr=%0d din=%0d",
                     obsWeN, obsAddr, obsDin, expWeN, expAddr, expDin);
        end
        setReq(0, 1'b1, 1'b0, 1, 16'h0);
        clockStep();
        checks++;
        if ({obsGnt0, obsGnt1} !== {expG0, expG1} || obsWeN !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rd_gnt actual gnt=%b%b we_n=%b expected gnt=%b%b we_n=1", obsGnt0, obsGnt1, obsWeN, expG0, expG1);
        end
        setReq(0, 1'b0, 1'b0, 0, 16'h0);
        for (int k = 0; k < 4; k++) begin
            clockStep();
            checks++;
            if ({obsRv0, obsRv1} !== {expRv0, expRv1}) begin
                failures++; $display("[TB] FAIL wr_rd_rvalid k=%0d actual=%b%b expected=%b%b", k, obsRv0, obsRv1, expRv0, expRv1);
            end
            if (k == 1) begin
                checks++;
                if (obsRv0 !== 1'b1 || obsRv1 !== 1'b0 || obsRd0 !== 16'd14514) begin
                    failures++;
                    $display("[TB] FAIL wr_rd_data actual rv=%b%b rd0=%0d expected rv=10 rd0=14514", obsRv0, obsRv1, obsRd0);
                end
            end
        end
    endtask

    task test_tie();
        doReset();
        setReq(0, 1'b1, 1'b0, 500, 16'h0);
        setReq(1, 1'b1, 1'b0, 996, 16'h0);
        clockStep();
        checks++;
        if ({obsGnt0, obsGnt1} !== {expG0, expG1}) begin
            failures++; $display("[TB] FAIL tie_first actual=%b%b expected=%b%b", obsGnt0, obsGnt1, expG0, expG1);
        end
        setReq(0, 1'b0, 1'b0, 0, 16'h0);
        clockStep();
        checks++;
        if ({obsGnt0, obsGnt1} !== {expG0, expG1}) begin
            failures++; $display("[TB] FAIL tie_second actual=%b%b expected=%b%b", obsGnt0, obsGnt1, expG0, expG1);
        end
        setReq(1, 1'b0, 1'b0, 0, 16'h0);
        for (int k = 0; k < 4; k++) begin
            clockStep();
            checks++;
            if ({obsRv0, obsRv1} !== {expRv0, expRv1}) begin
                failures++; $display("[TB] FAIL tie_rvalid k=%0d actual=%b%b expected=%b%b", k, obsRv0, obsRv1, expRv0, expRv1);
            end
            if (expRv0 || expRv1) begin
                checks++;
                if ((expRv0 ? obsRd0 : obsRd1) !== expData) begin
                    failures++; $display("[TB] FAIL tie_rdata k=%0d actual=%0d expected=%0d", k, expRv0 ? obsRd0 : obsRd1, expData);
                end
            end
        end
    endtask

    task test_burst();
        int leadRun;
        bit leadDone;
        leadRun  = 0;
        leadDone = 1'b0;
        doReset();
        newTxn(0);
        newTxn(1);
        for (int i = 0; i < 18; i++) begin
            if (i == 10) setReq(0, 1'b0, 1'b0, 0, 16'h0);
            clockStep();
            checks++;
            if ({obsGnt0, obsGnt1} !== {expG0, expG1}) begin
                failures++; $display("[TB] FAIL burst_gnt i=%0d actual=%b%b expected=%b%b", i, obsGnt0, obsGnt1, expG0, expG1);
            end
            checks++;
            if ({obsRv0, obsRv1} !== {expRv0, expRv1}) begin
                failures++; $display("[TB] FAIL burst_rvalid i=%0d actual=%b%b expected=%b%b", i, obsRv0, obsRv1, expRv0, expRv1);
            end
            if (expRv0 || expRv1) begin
                checks++;
                if ((expRv0 ? obsRd0 : obsRd1) !== expData) begin
                    failures++; $display("[TB] FAIL burst_rdata i=%0d actual=%0d expected=%0d", i, expRv0 ? obsRd0 : obsRd1, expData);
                end
            end
            if (!leadDone) begin
                if (obsGnt0 && !obsGnt1) leadRun++;
                else leadDone = 1'b1;
            end
            if (expGnt == 0 && i < 9) newTxn(0);
            if (expGnt == 1) newTxn(1);
        end
        checks++;
        if (leadRun !== MAXB) begin
            failures++; $display("[TB] FAIL burst_limit actual=%0d expected=%0d", leadRun, MAXB);
        end
        setReq(1, 1'b0, 1'b0, 0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            clockStep();
            checks++;
            if ({obsRv0, obsRv1} !== {expRv0, expRv1}) begin
                failures++; $display("[TB] FAIL burst_drain k=%0d actual=%b%b expected=%b%b", k, obsRv0, obsRv1, expRv0, expRv1);
            end
        end
    endtask

    task test_raw();
        setReq(1, 1'b1, 1'b1, 2596, 16'd30610);
        clockStep();
        checks++;
        if ({obsGnt0, obsGnt1} !== {expG0, expG1} || obsWeN !== expWeN) begin
            failures++;
            $display("[TB] FAIL raw_wr actual gnt=%b%b we_n=%b expected gnt=%b%b we_n=%b", obsGnt0, obsGnt1, obsWeN, expG0, expG1, expWeN);
        end
        setReq(1, 1'b0, 1'b0, 0, 16'h0);
        setReq(0, 1'b1, 1'b0, 2596, 16'h0);
        clockStep();
        checks++;
        if ({obsGnt0, obsGnt1} !== {expG0, expG1}) begin
            failures++; $display("[TB] FAIL raw_rd_gnt actual=%b%b expected=%b%b", obsGnt0, obsGnt1, expG0, expG1);
        end
        setReq(0, 1'b0, 1'b0, 0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            clockStep();
            if (k == 1) begin
                checks++;
                if (obsRv0 !== 1'b1 || obsRd0 !== 16'd30610) begin
                    failures++; $display("[TB] FAIL raw_data actual rv0=%b rd0=%0d expected rv0=1 rd0=30610", obsRv0, obsRd0);
                end
            end
        end
    endtask

    task test_random();
        for (int i = 0; i < 300; i++) begin
            if (!bus.rq0_req && $urandom_range(0, 99) < 60) newTxn(0);
            if (!bus.rq1_req && $urandom_range(0, 99) < 60) newTxn(1);
            clockStep();
            checks++;
            if ({obsGnt0, obsGnt1} !== {expG0, expG1}) begin
                failures++; $display("[TB] FAIL rand_gnt i=%0d actual=%b%b expected=%b%b", i, obsGnt0, obsGnt1, expG0, expG1);
            end
            checks++;
            if (obsWeN !== expWeN || obsAddr !== expAddr || obsDin !== expDin) begin
                failures++;
                $display("[TB] FAIL rand_membus i=%0d actual we_n=%b addr=%0d din=%0d expected we_n=%b addr=%0d din=%0d",
                         i, obsWeN, obsAddr, obsDin, expWeN, expAddr, expDin);
            end
            checks++;
            if ({obsRv0, obsRv1} !== {expRv0, expRv1}) begin
                failures++; $display("[TB] FAIL rand_rvalid i=%0d actual=%b%b expected=%b%b", i, obsRv0, obsRv1, expRv0, expRv1);
            end
            if (expRv0 || expRv1) begin
                checks++;
                if ((expRv0 ? obsRd0 : obsRd1) !== expData) begin
                    failures++; $display("[TB] FAIL rand_rdata i=%0d actual=%0d expected=%0d", i, expRv0 ? obsRd0 : obsRd1, expData);
                end
            end
            if (expGnt == 0) begin
                if ($urandom_range(0, 1) == 1) newTxn(0); else setReq(0, 1'b0, 1'b0, 0, 16'h0);
            end
            if (expGnt == 1) begin
                if ($urandom_range(0, 1) == 1) newTxn(1); else setReq(1, 1'b0, 1'b0, 0, 16'h0);
            end
        end
        setReq(0, 1'b0, 1'b0, 0, 16'h0);
        setReq(1, 1'b0, 1'b0, 0, 16'h0);
        repeat (3) clockStep();
    endtask

    task test_reset_midop();
        logic [15:0] saved;
        saved = refMem[3500];
        setReq(0, 1'b1, 1'b0, 3500, 16'h0);
        clockStep();
        setReq(0, 1'b0, 1'b0, 0, 16'h0);
        setReq(1, 1'b1, 1'b1, 3500, 16'hBEEF);
        clockStep();
        areset_n = 1'b0;
        refMem[3500] = saved;
        modelReset();
        setReq(0, 1'b1, 1'b0, 3500, 16'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.rq0_gnt, bus.rq1_gnt, bus.rq0_rvalid, bus.rq1_rvalid, bus.mem_write_enable_n} !== 5'b00001) begin
                failures++;
                $display("[TB] FAIL midrst_hold k=%0d actual gnt=%b%b rv=%b%b we_n=%b expected gnt=00 rv=00 we_n=1",
                         k, bus.rq0_gnt, bus.rq1_gnt, bus.rq0_rvalid, bus.rq1_rvalid, bus.mem_write_enable_n);
            end
        end
        @(posedge clk);
        #1;
        setReq(1, 1'b1, 1'b0, 7, 16'h0);
        areset_n = 1'b1;
        clockStep();
        checks++;
        if ({obsGnt0, obsGnt1, obsRv0, obsRv1} !== {expG0, expG1, expRv0, expRv1}) begin
            failures++;
            $display("[TB] FAIL midrst_first actual gnt=%b%b rv=%b%b expected gnt=%b%b rv=%b%b",
                     obsGnt0, obsGnt1, obsRv0, obsRv1, expG0, expG1, expRv0, expRv1);
        end
        setReq(0, 1'b0, 1'b0, 0, 16'h0);
        clockStep();
        setReq(1, 1'b0, 1'b0, 0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            clockStep();
            checks++;
            if ({obsRv0, obsRv1} !== {expRv0, expRv1}) begin
                failures++; $display("[TB] FAIL midrst_rvalid k=%0d actual=%b%b expected=%b%b", k, obsRv0, obsRv1, expRv0, expRv1);
            end
            if (k == 0) begin
                checks++;
                if (obsRv0 !== 1'b1 || obsRd0 !== saved) begin
                    failures++; $display("[TB] FAIL midrst_drop actual rv0=%b rd0=%0d expected rv0=1 rd0=%0d", obsRv0, obsRd0, saved);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_burst();
        test_raw();
        test_random();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem16kb_arbiter.md
MEM16KB_ARBITER -- requirements
Module: mem16kb_arbiter

Interface
REQ-001 Parameter: AWIDTH, 12, memory address width.
REQ-002 Parameter: DWIDTH, 16, memory data width.
REQ-003 Parameter: MAX_BURST, 4, maximum consecutive accepts for one requester while the other is requesting.
REQ-004 Ports: clk  in  1  single clock, all flops on rising edge.
REQ-005 Ports: areset_n  in  1  asynchronous, active-low reset.
REQ-006 Ports: rq0_req / rq1_req  in  1  access request, held until accepted.
REQ-007 Ports: rq0_wr / rq1_wr  in  1  1 = write, 0 = read.
REQ-008 Ports: rq0_addr / rq1_addr  in  AWIDTH  access address.
REQ-009 Ports: rq0_wdata / rq1_wdata  in  DWIDTH  write data.
REQ-010 Ports: rq0_gnt / rq1_gnt  out  1  combinational grant; accept = req & gnt.
REQ-011 Ports: rq0_rvalid / rq1_rvalid  out  1  one-cycle pulse, read data valid.
REQ-012 Ports: rq0_rdata / rq1_rdata  out  DWIDTH  read data, held until next rvalid for that requester.
REQ-013 Ports: mem_address  out  AWIDTH  to mem16kb address, registered.
REQ-014 Ports: mem_data_in  out  DWIDTH  to mem16kb data_in, registered.
REQ-015 Ports: mem_write_enable_n  out  1  to mem16kb write_enable_n, active-low, registered.
REQ-016 Ports: mem_data_out  in  DWIDTH  from mem16kb data_out; valid the cycle after mem16kb samples a read address.

Function
REQ-017 At most one of rq0_gnt, rq1_gnt SHALL be high in any cycle; both SHALL be 0 while areset_n is low.
REQ-018 States: IDLE, OWN0, OWN1; state, last-served pointer and burst_cnt (width clog2(MAX_BURST)+1) registered.
REQ-019 IDLE: single requester -> grant it; both -> grant the one not last served; none -> stay IDLE.
REQ-020 OWNx: grant x if rqx_req and (other idle or burst_cnt < MAX_BURST); else grant other if requesting; else go IDLE.
REQ-021 Accept by owner increments burst_cnt (saturating); accept by new owner sets burst_cnt = 1 and moves to that OWN state.
REQ-022 Accept at edge N SHALL load mem_address/mem_data_in/mem_write_enable_n (0 for write, 1 for read) at edge N; no accept -> mem_write_enable_n = 1, address and data held.
REQ-023 One accept per cycle, fully pipelined; back-to-back accepts from either requester SHALL be serviced without bubbles.
REQ-024 Read accepted at edge N: data captured from mem_data_out at edge N+2; matching rqx_rvalid high for the cycle after edge N+2, other rvalid low.
REQ-025 Writes produce no rvalid; memory updated at edge N+1.
REQ-026 Requester id and read flag tracked through a 2-stage pipeline; rvalid SHALL follow accept order.
REQ-027 Read accepted the cycle after a write to the same address SHALL return the new data.

Reset
REQ-028 On areset_n low: state IDLE, last-served = rq1 (rq0 wins first tie), burst_cnt 0, mem_address 0, mem_data_in 0, mem_write_enable_n 1, rvalid 0, rdata 0, pipeline flushed.
REQ-029 Reset mid-operation: in-flight reads discarded; no rvalid for pre-reset accepts; a write registered but not sampled by mem16kb before reset SHALL be dropped.

Structure
REQ-030 Shared package mem_arb_pkg: AWIDTH, DWIDTH defaults, state enum (IDLE/OWN0/OWN1), requester-id type.
REQ-031 One sub-module rr2_grant: FSM, pointer, burst counter, grant outputs; top holds memory registers and read pipeline.

Verification
REQ-032 rq0 writes 14514 @1, then reads @1 -> rq0_rvalid 2 cycles after read accept, rq0_rdata = 14514, rq1_rvalid 0.
REQ-033 Both req from reset, reads @500 and @996 -> rq0 granted first, rq1 next cycle; rvalids in same order, no gap.
REQ-034 rq0 holds req 10 cycles, rq1 requests from cycle 0, MAX_BURST=4 -> rq0 max 4 consecutive accepts, rq1 granted next, alternation continues.
REQ-035 rq1 writes 30610 @2596, rq0 reads @2596 next cycle -> rq0_rdata = 30610.
REQ-036 areset_n low one cycle after read accept @3500 -> no rvalid afterward, mem_write_enable_n 1, gnt 0 during reset, state IDLE.
